// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-ported register file with a per-register busy scoreboard,
// allocation ports that reserve destinations, writeback release and flush.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n_in,
  input  logic [NREAD*AW-1:0]    rs_in,
  output logic [NREAD*XLEN-1:0]  rdata_out,
  output logic [NREAD-1:0]       rbusy_out,
  input  logic [NWRITE-1:0]      we_in,
  input  logic [NWRITE*AW-1:0]   wa_in,
  input  logic [NWRITE*XLEN-1:0] wd_in,
  input  logic [NWRITE-1:0]      alloc_valid_in,
  input  logic [NWRITE*AW-1:0]   alloc_rd_in,
  output logic [NWRITE-1:0]      alloc_grant_out,
  input  logic                   flush_in,
  output logic [AW:0]            busy_count_out
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic [AW:0]      count_nxt;

  genvar k, i;
  for (k = 0; k < NWRITE; k++) begin : g_alloc
    logic [AW-1:0] rd;
    logic dup;
    assign rd = alloc_rd_in[k*AW +: AW];
    // a lower-index request for the same register wins even if it is itself refused
    always_comb begin
      dup = 1'b0;
      for (int m = 0; m < k; m++)
        if (alloc_valid_in[m] && alloc_rd_in[m*AW +: AW] == rd) dup = 1'b1;
    end
    assign alloc_grant_out[k] = alloc_valid_in[k] & ~flush_in & (rd == '0 | (~busy[rd] & ~dup));
  end

  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWRITE; j++)
      if (we_in[j]) busy_nxt[wa_in[j*AW +: AW]] = 1'b0;
    for (int j = 0; j < NWRITE; j++)
      if (alloc_grant_out[j]) busy_nxt[alloc_rd_in[j*AW +: AW]] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (flush_in) busy_nxt = '0;
    count_nxt = '0;
    for (int r = 0; r < NREGS; r++) count_nxt = count_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
      busy_count_out <= '0;
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      busy <= busy_nxt;
      busy_count_out <= count_nxt;
      for (int j = 0; j < NWRITE; j++)
        if (we_in[j] && wa_in[j*AW +: AW] != '0) regs[wa_in[j*AW +: AW]] <= wd_in[j*XLEN +: XLEN];
    end
  end

  for (i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]   rs;
    logic            hit, byp;
    logic [XLEN-1:0] bd;
    assign rs = rs_in[i*AW +: AW];
    always_comb begin
      hit = 1'b0;
      bd = '0;
      for (int j = 0; j < NWRITE; j++)
        if (we_in[j] && wa_in[j*AW +: AW] == rs) begin
          hit = 1'b1;
          bd = wd_in[j*XLEN +: XLEN];
        end
    end
    assign byp = (BYPASS != 0) && hit && rs != '0;
    assign rdata_out[i*XLEN +: XLEN] = rs == '0 ? '0 : byp ? bd : regs[rs];
    assign rbusy_out[i] = rs != '0 && !byp && busy[rs];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed test of a bypassing and a non-bypassing instance
// driven by the same stimulus.
module tb_regfile_scoreboard;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [19:0]  rs;
  logic [127:0] rdata1, rdata0;
  logic [3:0]   rbusy1, rbusy0;
  logic [1:0]   we, av, g1, g0;
  logic [9:0]   wa, ard;
  logic [63:0]  wd;
  logic         flush;
  logic [5:0]   cnt1, cnt0;
  int           total = 0, passed = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .clk_100mhz(clk), .rst_n_in(rst_n), .rs_in(rs), .rdata_out(rdata1), .rbusy_out(rbusy1),
    .we_in(we), .wa_in(wa), .wd_in(wd), .alloc_valid_in(av), .alloc_rd_in(ard),
    .alloc_grant_out(g1), .flush_in(flush), .busy_count_out(cnt1));

  regfile_scoreboard #(.BYPASS(0)) dut0 (
    .clk_100mhz(clk), .rst_n_in(rst_n), .rs_in(rs), .rdata_out(rdata0), .rbusy_out(rbusy0),
    .we_in(we), .wa_in(wa), .wd_in(wd), .alloc_valid_in(av), .alloc_rd_in(ard),
    .alloc_grant_out(g0), .flush_in(flush), .busy_count_out(cnt0));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = '0;
    av = '0;
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs = '0; wa = '0; wd = '0; ard = '0;
    idle();
    #1;
    chk("reset_cnt", cnt1, 0);
    chk("reset_cnt0", cnt0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int r = 0; r < 32; r++) begin
      rs[4:0] = 5'(r);
      #1;
      chk("reset_read", rdata1[31:0], 0);
      chk("reset_busy", rbusy1[0], 0);
    end
    // x0 ignores writes
    we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'hDEADBEEF; rs[4:0] = 5'd0;
    #1;
    chk("x0_byp", rdata1[31:0], 0);
    chk("x0_busy", rbusy1[0], 0);
    tick(); idle();
    #1;
    chk("x0_stored", rdata0[31:0], 0);
    // basic write and bypass
    we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'h12345678; rs[4:0] = 5'd5;
    #1;
    chk("byp_same", rdata1[31:0], 32'h12345678);
    chk("nobyp_same", rdata0[31:0], 0);
    tick(); idle();
    #1;
    chk("nobyp_next", rdata0[31:0], 32'h12345678);
    chk("byp_next", rdata1[31:0], 32'h12345678);
    // write collision: highest port wins
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2, 32'h1}; rs[9:5] = 5'd7;
    #1;
    chk("coll_byp", rdata1[63:32], 32'h2);
    chk("coll_nobyp", rdata0[63:32], 0);
    tick(); idle();
    #1;
    chk("coll_stored", rdata0[63:32], 32'h2);
    // scoreboard reserve / refuse / release
    av = 2'b01; ard[4:0] = 5'd3;
    #1;
    chk("alloc_x3", g1, 2'b01);
    tick(); idle();
    rs[14:10] = 5'd3;
    #1;
    chk("x3_busy", rbusy1[2], 1);
    chk("x3_busy0", rbusy0[2], 1);
    chk("cnt_1", cnt1, 1);
    av = 2'b01;
    #1;
    chk("realloc_x3", g1, 2'b00);
    tick(); idle();
    we = 2'b10; wa[9:5] = 5'd3; wd[63:32] = 32'h33;
    #1;
    chk("x3_byp_notbusy", rbusy1[2], 0);
    chk("x3_nobyp_busy", rbusy0[2], 1);
    tick(); idle();
    #1;
    chk("x3_released", rbusy0[2], 0);
    chk("cnt_0", cnt1, 0);
    chk("x3_data", rdata0[95:64], 32'h33);
    // same-cycle duplicate alloc
    av = 2'b11; ard = {5'd9, 5'd9};
    #1;
    chk("dup_grant", g1, 2'b01);
    tick(); idle();
    #1;
    chk("dup_cnt", cnt1, 1);
    // alloc while being written and busy: refused, busy clears
    av = 2'b01; ard[4:0] = 5'd4;
    tick(); idle();
    #1;
    chk("x4_cnt", cnt1, 2);
    we = 2'b01; wa[4:0] = 5'd4; wd[31:0] = 32'h44; av = 2'b01; ard[4:0] = 5'd4; rs[19:15] = 5'd4;
    #1;
    chk("x4_refused", g1, 2'b00);
    tick(); idle();
    #1;
    chk("x4_clear", rbusy0[3], 0);
    chk("x4_cnt_after", cnt1, 1);
    // alloc x0 is granted with no effect
    av = 2'b01; ard[4:0] = 5'd0;
    #1;
    chk("x0_grant", g1, 2'b01);
    tick(); idle();
    #1;
    chk("x0_cnt", cnt1, 1);
    // release x9 while reserving x1/x2, then x3
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h99; av = 2'b11; ard = {5'd2, 5'd1};
    #1;
    chk("x12_grant", g1, 2'b11);
    tick(); idle();
    #1;
    chk("x12_cnt", cnt1, 2);
    av = 2'b01; ard[4:0] = 5'd3;
    tick(); idle();
    #1;
    chk("pre_flush_cnt", cnt1, 3);
    chk("pre_flush_cnt0", cnt0, 3);
    // flush: grants forced low, busy cleared, writes still commit
    flush = 1'b1; av = 2'b01; ard[4:0] = 5'd6; we = 2'b01; wa[4:0] = 5'd2; wd[31:0] = 32'hAA; rs[4:0] = 5'd2;
    #1;
    chk("flush_grant", g1, 2'b00);
    chk("flush_grant0", g0, 2'b00);
    tick(); idle();
    #1;
    chk("flush_cnt", cnt1, 0);
    chk("flush_write", rdata0[31:0], 32'hAA);
    chk("flush_x2_busy", rbusy0[0], 0);
    // asynchronous reset mid-operation
    av = 2'b01; ard[4:0] = 5'd8;
    tick(); idle();
    #1;
    chk("x8_cnt", cnt1, 1);
    rs[4:0] = 5'd5; we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hFFFF;
    #1 rst_n = 1'b0;
    #1;
    chk("async_cnt", cnt1, 0);
    chk("async_x5", rdata0[31:0], 0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    idle();
    tick();
    chk("reset_write_lost", rdata0[31:0], 0);
    chk("reset_busy_lost", cnt0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Multi-ported integer register file with a per-register busy scoreboard, used by the multi-issue core. It serves NREAD combinational operand reads and NWRITE writebacks per cycle. Optional same-cycle writeback-to-read bypass is provided. Issue logic reserves destination registers through allocation ports; writeback releases them. A flush input clears all reservations on a pipeline squash.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥2); AW = $clog2(NREGS)
- NREAD, 4, read ports
- NWRITE, 2, write ports and allocation ports
- BYPASS, 1, 1 = reads see same-cycle writeback data; 0 = reads see stored value

Ports:
- clk_100mhz  in  1  clock; all state updates on rising edge
- rst_n_in  in  1  asynchronous active-low reset
- rs_in  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rdata_out  out  NREAD*XLEN  read data, combinational
- rbusy_out  out  NREAD  read port i's register has a pending producer
- we_in  in  NWRITE  write enables
- wa_in  in  NWRITE*AW  write addresses
- wd_in  in  NWRITE*XLEN  write data
- alloc_valid_in  in  NWRITE  allocation requests
- alloc_rd_in  in  NWRITE*AW  destination registers to reserve
- alloc_grant_out  out  NWRITE  request granted, combinational
- flush_in  in  1  clear all busy bits
- busy_count_out  out  AW+1  registered population count of busy bits

## Operation
- State: regs[NREGS] of XLEN bits; busy[NREGS] of 1 bit. Register 0 reads 0, ignores writes, and is never busy.
- Write: port j with we_in[j] and wa≠0 stores wd_in[j]. If several ports write the same address in a cycle, the highest index j wins.
- Writeback release: any enabled write to r clears busy[r] next edge, unless r is re-reserved that cycle (see alloc).
- Alloc grant, port k: alloc_valid_in[k] & !flush_in & (rd==0 | (!busy[rd] & no lower-index port k' with valid and the same nonzero rd)). Grant uses registered busy. A register busy at the start of the cycle is refused even if released the same cycle. Granted nonzero rd sets busy[rd] next edge. Set dominates clear.
- Refused requests have no side effect. Issue logic must re-present them.
- flush_in: all busy bits 0 next edge, and all grants are forced low. Register writes in the same cycle still commit.
- Read i, BYPASS=1: if some enabled write port has wa == rs (rs≠0), rdata = wd of the highest such port, and rbusy_out[i] = 0. Otherwise rdata = regs[rs] and rbusy_out[i] = busy[rs].
- Read i, BYPASS=0: rdata = regs[rs] and rbusy_out[i] = busy[rs], regardless of writes.
- rs = 0: rdata 0 and rbusy 0 always.
- busy_count_out: count of set busy bits, updated with busy.

## Timing
- Reset (async assert, sync-safe release): regs all 0, busy all 0, busy_count_out 0. Combinational outputs then follow the reset state: rdata 0, rbusy 0, and grants reflect current requests.
- Reset asserted mid-operation: state clears immediately. Writes and allocs in that cycle are lost.
- Read latency: 0 cycles, combinational from rs_in and the write ports.
- Write latency: 1 edge. Under BYPASS=0, the value is visible on the read port the cycle after we_in.
- Alloc: grant is combinational in the request cycle. busy is visible on rbusy_out the next cycle.
- No combinational path from alloc_* to rdata_out or rbusy_out.

## Test plan
- Reset/x0: after reset, read all regs -> 0 and busy_count 0. Write x0=0xDEADBEEF -> x0 still reads 0, not busy.
- Basic and bypass: write x5=0x12345678 on port 0 while reading x5. BYPASS=1 -> same-cycle rdata 0x12345678. BYPASS=0 -> old 0, then 0x12345678 next cycle.
- Write collision: ports 0 and 1 both write x7 (0x1, 0x2) -> x7 = 0x2. The bypass read also returns 0x2.
- Scoreboard: alloc x3 -> grant=1, next cycle rbusy=1, count=1. Alloc x3 again -> grant=0. Write x3 -> next cycle busy clear, count=0.
- Conflicts: ports 0 and 1 both alloc x9 -> grant=2'b01. Alloc x4 while x4 is being written and busy -> refused, and busy clears. Alloc x0 -> granted, count unchanged.
- Flush: reserve x1, x2, x3 (count=3), then flush with alloc x6 -> grant=0, next cycle count=0. A write of 0xAA to x2 in the flush cycle -> x2=0xAA.
